// File: rtl/seq_gen_pkg.sv
// Shared types and constants for the sequence-detector family.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Default 4-bit pattern; also the target of the 1011 detector benches.
  localparam logic [3:0] DEF_PAT = 4'b1011;

endpackage

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: sends a latched pattern MSB-first, a
// programmable number of times, with an optional idle gap between repeats.
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int unsigned      PAT_W   = 4,
  parameter int unsigned      CNT_W   = 8,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(seq_gen_pkg::DEF_PAT)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [CNT_W-1:0] gap_cnt,
  output logic             busy,
  output logic             dout,
  output logic             dout_valid,
  output logic             pat_last,
  output logic             done
);

  localparam int unsigned      IDX_W   = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PAT_W - 1);

  state_t           r_state, w_state;
  logic [PAT_W-1:0] r_pat, w_pat;
  logic [IDX_W-1:0] r_idx, w_idx;
  logic [CNT_W-1:0] r_rem, w_rem;
  logic [CNT_W-1:0] r_gap_len, w_gap_len;
  logic [CNT_W-1:0] r_gap, w_gap;
  logic             r_busy, w_busy;
  logic             r_dout, w_dout;
  logic             r_valid, w_valid;
  logic             r_last, w_last;
  logic             r_done, w_done;

  // State, counters, latched parameters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_pat     <= DEF_PAT;
      r_idx     <= '0;
      r_rem     <= '0;
      r_gap_len <= '0;
      r_gap     <= '0;
      r_busy    <= 1'b0;
      r_dout    <= 1'b0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_pat     <= w_pat;
      r_idx     <= w_idx;
      r_rem     <= w_rem;
      r_gap_len <= w_gap_len;
      r_gap     <= w_gap;
      r_busy    <= w_busy;
      r_dout    <= w_dout;
      r_valid   <= w_valid;
      r_last    <= w_last;
      r_done    <= w_done;
    end
  end

  // Next-state and counter logic; outputs are decoded from the next state
  // so that the registered outputs line up with the state they describe.
  always_comb begin
    w_state   = r_state;
    w_pat     = r_pat;
    w_idx     = r_idx;
    w_rem     = r_rem;
    w_gap_len = r_gap_len;
    w_gap     = r_gap;
    w_busy    = 1'b0;
    w_dout    = 1'b0;
    w_valid   = 1'b0;
    w_last    = 1'b0;
    w_done    = 1'b0;

    unique case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_pat     = pattern;
          w_rem     = repeat_cnt;
          w_gap_len = gap_cnt;
          w_idx     = IDX_MAX;
          w_state   = (repeat_cnt == '0) ? DONE : SEND;
        end else begin
          w_state = IDLE;
        end
      end
      SEND: begin
        if (r_idx == '0) begin
          w_rem = r_rem - CNT_W'(1);
          if (r_rem == CNT_W'(1)) begin
            w_state = DONE;
          end else if (r_gap_len == '0) begin
            w_idx = IDX_MAX;
          end else begin
            w_state = GAP;
            w_gap   = r_gap_len;
          end
        end else begin
          w_idx = r_idx - IDX_W'(1);
        end
      end
      GAP: begin
        if (r_gap == CNT_W'(1)) begin
          w_state = SEND;
          w_idx   = IDX_MAX;
        end else begin
          w_gap = r_gap - CNT_W'(1);
        end
      end
      default: w_state = IDLE;
    endcase

    unique case (w_state)
      SEND: begin
        w_busy  = 1'b1;
        w_valid = 1'b1;
        w_dout  = w_pat[w_idx];
        w_last  = (w_idx == '0);
      end
      GAP:     w_busy = 1'b1;
      DONE:    w_done = 1'b1;
      default: ;
    endcase
  end

  assign busy       = r_busy;
  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign pat_last   = r_last;
  assign done       = r_done;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen with hand-computed per-cycle vectors.
module tb_seq_pattern_gen;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [3:0] pattern;
  logic [7:0] repeat_cnt;
  logic [7:0] gap_cnt;
  logic       busy, dout, dout_valid, pat_last, done;

  int n_checks = 0;
  int n_fail   = 0;

  seq_pattern_gen #(
    .PAT_W(4),
    .CNT_W(8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .pattern   (pattern),
    .repeat_cnt(repeat_cnt),
    .gap_cnt   (gap_cnt),
    .busy      (busy),
    .dout      (dout),
    .dout_valid(dout_valid),
    .pat_last  (pat_last),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one rising edge; the next negedge is cycle 1.
  task automatic launch(input logic [3:0] p, input logic [7:0] r, input logic [7:0] g);
    @(negedge clk);
    pattern    = p;
    repeat_cnt = r;
    gap_cnt    = g;
    start      = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] obs;
    reset_n = 1'b0;
    #1;
    obs = {busy, dout_valid, dout, pat_last, done};
    n_checks++;
    if (obs !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_async: got b/v/d/l/dn=%b want %b", obs, 5'b0);
    end
    repeat (2) @(negedge clk);
    obs = {busy, dout_valid, dout, pat_last, done};
    n_checks++;
    if (obs !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_held: got b/v/d/l/dn=%b want %b", obs, 5'b0);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    obs = {busy, dout_valid, dout, pat_last, done};
    n_checks++;
    if (obs !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got b/v/d/l/dn=%b want %b", obs, 5'b0);
    end
  endtask

  // 1011, R=1, G=0
  task automatic test_basic();
    logic [5:0] e_b, e_v, e_d, e_l, e_dn;
    logic [4:0] obs, exp;
    e_b = 6'b111100; e_v = 6'b111100; e_d = 6'b101100;
    e_l = 6'b000100; e_dn = 6'b000010;
    launch(4'b1011, 8'd1, 8'd0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      obs = {busy, dout_valid, dout, pat_last, done};
      exp = {e_b[6-k], e_v[6-k], e_d[6-k], e_l[6-k], e_dn[6-k]};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL basic c%0d: got b/v/d/l/dn=%b want %b", k, obs, exp);
      end
    end
  endtask

  // 1011, R=3, G=2
  task automatic test_gap();
    logic [16:0] e_b, e_v, e_d, e_l, e_dn;
    logic [4:0] obs, exp;
    e_b  = 17'b11111111111111110;
    e_v  = 17'b11110011110011110;
    e_d  = 17'b10110010110010110;
    e_l  = 17'b00010000010000010;
    e_dn = 17'b00000000000000001;
    launch(4'b1011, 8'd3, 8'd2);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      obs = {busy, dout_valid, dout, pat_last, done};
      exp = {e_b[17-k], e_v[17-k], e_d[17-k], e_l[17-k], e_dn[17-k]};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL gap c%0d: got b/v/d/l/dn=%b want %b", k, obs, exp);
      end
    end
  endtask

  // R=0: done in cycle 1 only, nothing sent
  task automatic test_zero_repeat();
    logic [4:0] obs, exp;
    launch(4'b1111, 8'd0, 8'd3);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      obs = {busy, dout_valid, dout, pat_last, done};
      exp = (k == 1) ? 5'b00001 : 5'b00000;
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL zero_rep c%0d: got b/v/d/l/dn=%b want %b", k, obs, exp);
      end
    end
  endtask

  // 1101, R=2, G=0: contiguous bits
  task automatic test_no_gap();
    logic [8:0] e_b, e_v, e_d, e_l, e_dn;
    logic [4:0] obs, exp;
    e_b = 9'b111111110; e_v = 9'b111111110; e_d = 9'b110111010;
    e_l = 9'b000100010; e_dn = 9'b000000001;
    launch(4'b1101, 8'd2, 8'd0);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      obs = {busy, dout_valid, dout, pat_last, done};
      exp = {e_b[9-k], e_v[9-k], e_d[9-k], e_l[9-k], e_dn[9-k]};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL no_gap c%0d: got b/v/d/l/dn=%b want %b", k, obs, exp);
      end
    end
  endtask

  // Start while busy is ignored; start in the done cycle launches next.
  task automatic test_back_to_back();
    logic [9:0] e_b, e_v, e_d, e_l, e_dn;
    logic [4:0] obs, exp;
    e_b = 10'b1111011110; e_v = 10'b1111011110; e_d = 10'b1011001100;
    e_l = 10'b0001000010; e_dn = 10'b0000100001;
    launch(4'b1011, 8'd1, 8'd0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      obs = {busy, dout_valid, dout, pat_last, done};
      exp = {e_b[10-k], e_v[10-k], e_d[10-k], e_l[10-k], e_dn[10-k]};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL b2b c%0d: got b/v/d/l/dn=%b want %b", k, obs, exp);
      end
      if (k == 2) begin
        start = 1'b1; pattern = 4'b0100; repeat_cnt = 8'd5; gap_cnt = 8'd3;
      end else if (k == 5) begin
        start = 1'b1; pattern = 4'b0110; repeat_cnt = 8'd1; gap_cnt = 8'd0;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  // Reset in cycle 3 of a R=2 run, then a fresh run behaves normally.
  task automatic test_reset_mid();
    logic [4:0] obs, exp;
    launch(4'b1011, 8'd2, 8'd0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      obs = {busy, dout_valid, dout, pat_last, done};
      exp = (k == 2) ? 5'b11000 : 5'b11100;
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL rst_pre c%0d: got b/v/d/l/dn=%b want %b", k, obs, exp);
      end
    end
    #1 reset_n = 1'b0;
    #1;
    obs = {busy, dout_valid, dout, pat_last, done};
    n_checks++;
    if (obs !== 5'b0) begin
      n_fail++;
      $display("FAIL rst_async: got b/v/d/l/dn=%b want %b", obs, 5'b0);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      obs = {busy, dout_valid, dout, pat_last, done};
      n_checks++;
      if (obs !== 5'b0) begin
        n_fail++;
        $display("FAIL rst_held c%0d: got b/v/d/l/dn=%b want %b", k, obs, 5'b0);
      end
    end
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      obs = {busy, dout_valid, dout, pat_last, done};
      n_checks++;
      if (obs !== 5'b0) begin
        n_fail++;
        $display("FAIL rst_idle c%0d: got b/v/d/l/dn=%b want %b", k, obs, 5'b0);
      end
    end
    test_basic();
  endtask

  // Full-scale counters: R=255 G=0, then R=2 G=255.
  task automatic test_max_counts();
    int done_cyc, n_valid, n_last, n_gap;
    for (int s = 0; s < 2; s++) begin
      int exp_done, exp_valid, exp_last, exp_gap;
      logic [7:0] r, g;
      r = (s == 0) ? 8'd255 : 8'd2;
      g = (s == 0) ? 8'd0   : 8'd255;
      exp_valid = int'(r) * 4;
      exp_gap   = (int'(r) - 1) * int'(g);
      exp_done  = exp_valid + exp_gap + 1;
      exp_last  = int'(r);
      done_cyc = 0; n_valid = 0; n_last = 0; n_gap = 0;
      launch(4'b1011, r, g);
      for (int k = 1; k <= 2000; k++) begin
        @(negedge clk);
        if (dout_valid) n_valid++;
        if (pat_last)   n_last++;
        if (busy && !dout_valid) n_gap++;
        if (done) begin
          done_cyc = k;
          break;
        end
      end
      n_checks++;
      if (done_cyc !== exp_done) begin
        n_fail++;
        $display("FAIL max%0d_done_cycle: got %0d want %0d", s, done_cyc, exp_done);
      end
      n_checks++;
      if (n_valid !== exp_valid) begin
        n_fail++;
        $display("FAIL max%0d_valid_count: got %0d want %0d", s, n_valid, exp_valid);
      end
      n_checks++;
      if (n_last !== exp_last) begin
        n_fail++;
        $display("FAIL max%0d_last_count: got %0d want %0d", s, n_last, exp_last);
      end
      n_checks++;
      if (n_gap !== exp_gap) begin
        n_fail++;
        $display("FAIL max%0d_gap_count: got %0d want %0d", s, n_gap, exp_gap);
      end
    end
  endtask

  initial begin
    start      = 1'b0;
    pattern    = 4'b0000;
    repeat_cnt = 8'd0;
    gap_cnt    = 8'd0;
    reset_n    = 1'b0;
    test_reset();
    test_basic();
    test_gap();
    test_zero_repeat();
    test_no_gap();
    test_back_to_back();
    test_reset_mid();
    test_max_counts();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
